// File: rtl/lynx_flit_pkg.sv
// Shared flit definitions for the lynx NoC endpoints.
//   - state_e   : depacketizer control states
//   - p1 / p2   : payload widths of head and body/tail flits
//   - *_pos/*_lsb : bit positions of the header fields
// Flit layout, MSB first: valid, head, tail, vc, [dst on head flits], payload.
package lynx_flit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TAIL,
    ST_HOLD
  } state_e;

  // Payload width of a head flit (carries the dst field).
  function automatic int p1(input int fw, input int aw, input int vcw);
    return fw - 3 - aw - vcw;
  endfunction

  // Payload width of a body/tail flit (no dst field).
  function automatic int p2(input int fw, input int vcw);
    return fw - 3 - vcw;
  endfunction

  function automatic int valid_pos(input int fw);
    return fw - 1;
  endfunction

  function automatic int head_pos(input int fw);
    return fw - 2;
  endfunction

  function automatic int tail_pos(input int fw);
    return fw - 3;
  endfunction

  function automatic int vc_lsb(input int fw, input int vcw);
    return fw - 3 - vcw;
  endfunction

  function automatic int dst_lsb(input int fw, input int aw, input int vcw);
    return fw - 3 - vcw - aw;
  endfunction

endpackage

// File: rtl/flit_field_decode.sv
// Combinational header split of one flit.
//   flit_i         : raw flit
//   valid_bit_o    : flit valid bit
//   head_o/tail_o  : head / tail markers
//   vc_o           : VC field
//   dst_o          : dst field (meaningful on head flits only)
//   head_payload_o : payload as seen on a head flit
//   body_payload_o : payload as seen on a body/tail flit
module flit_field_decode
  import lynx_flit_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int FLIT_WIDTH       = 18,
  localparam int P1 = p1(FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH),
  localparam int P2 = p2(FLIT_WIDTH, VC_ADDRESS_WIDTH)
) (
  input  logic [FLIT_WIDTH-1:0]       flit_i,
  output logic                        valid_bit_o,
  output logic                        head_o,
  output logic                        tail_o,
  output logic [VC_ADDRESS_WIDTH-1:0] vc_o,
  output logic [ADDRESS_WIDTH-1:0]    dst_o,
  output logic [P1-1:0]               head_payload_o,
  output logic [P2-1:0]               body_payload_o
);

  assign valid_bit_o    = flit_i[valid_pos(FLIT_WIDTH)];
  assign head_o         = flit_i[head_pos(FLIT_WIDTH)];
  assign tail_o         = flit_i[tail_pos(FLIT_WIDTH)];
  assign vc_o           = flit_i[vc_lsb(FLIT_WIDTH, VC_ADDRESS_WIDTH) +: VC_ADDRESS_WIDTH];
  assign dst_o          = flit_i[dst_lsb(FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH) +: ADDRESS_WIDTH];
  assign head_payload_o = flit_i[P1-1:0];
  assign body_payload_o = flit_i[P2-1:0];

endmodule

// File: rtl/depacketizer_2.sv
// Reassembles a head+tail flit pair (or a single head/tail flit) into one
// output word with valid/ready handshake and counts protocol errors.
//   clk, rst_n        : clock, async active-low reset
//   flit_in           : flit from the router
//   flit_valid_in     : flit_in present
//   flit_ready_out    : a flit is accepted this cycle
//   data_out          : reassembled word (head payload MSBs, tail payload LSBs)
//   dst_out / vc_out  : head-flit dst / vc fields
//   valid_out         : outputs valid (held until ready_in)
//   ready_in          : consumer takes the word
//   err_count         : saturating protocol error count
module depacketizer_2
  import lynx_flit_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int FLIT_WIDTH       = 18,
  parameter int WIDTH_DATA       = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [FLIT_WIDTH-1:0]       flit_in,
  input  logic                        flit_valid_in,
  output logic                        flit_ready_out,
  output logic [WIDTH_DATA-1:0]       data_out,
  output logic [ADDRESS_WIDTH-1:0]    dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [7:0]                  err_count
);

  localparam int P1 = p1(FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
  localparam int P2 = p2(FLIT_WIDTH, VC_ADDRESS_WIDTH);
  // Bits taken from the head payload, remainder from the tail payload.
  localparam int H  = (P1 < WIDTH_DATA) ? P1 : WIDTH_DATA;
  localparam int T  = WIDTH_DATA - H;

  logic                        f_valid, f_head, f_tail;
  logic [VC_ADDRESS_WIDTH-1:0] f_vc;
  logic [ADDRESS_WIDTH-1:0]    f_dst;
  logic [P1-1:0]               head_payload;
  logic [P2-1:0]               body_payload;

  flit_field_decode #(
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .VC_ADDRESS_WIDTH(VC_ADDRESS_WIDTH),
    .FLIT_WIDTH      (FLIT_WIDTH)
  ) u_decode (
    .flit_i        (flit_in),
    .valid_bit_o   (f_valid),
    .head_o        (f_head),
    .tail_o        (f_tail),
    .vc_o          (f_vc),
    .dst_o         (f_dst),
    .head_payload_o(head_payload),
    .body_payload_o(body_payload)
  );

  // Padding bits of the payloads are don't-care.
  logic unused_payload;
  assign unused_payload = ^{head_payload, body_payload};

  state_e                      state_q, state_d;
  logic [WIDTH_DATA-1:0]       data_q, data_d;
  logic [ADDRESS_WIDTH-1:0]    dst_q, dst_d;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_d;
  logic [7:0]                  err_q, err_d;

  logic                        accept, load_head, load_tail, err_ev;
  logic [WIDTH_DATA-1:0]       head_word, tail_word;

  // Flits with the valid bit clear are consumed but otherwise ignored.
  assign accept    = flit_valid_in & f_valid & flit_ready_out;
  // A head always starts a new packet, also in HOLD (no bubble) and in
  // WAIT_TAIL (partial packet dropped).
  assign load_head = accept & f_head;
  assign load_tail = accept & ~f_head & f_tail & (state_q == ST_WAIT_TAIL);
  assign err_ev    = accept & ((state_q == ST_WAIT_TAIL) ? (f_head | ~f_tail) : ~f_head);

  generate
    if (T > 0) begin : g_split
      assign head_word = {head_payload[P1-1 -: H], {T{1'b0}}};
      assign tail_word = {data_q[WIDTH_DATA-1 -: H], body_payload[P2-1 -: T]};
    end else begin : g_head_only
      assign head_word = head_payload[P1-1 -: H];
      assign tail_word = data_q;
    end
  endgenerate

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_head) state_d = f_tail ? ST_HOLD : ST_WAIT_TAIL;
      end
      ST_WAIT_TAIL: begin
        if (load_head)      state_d = f_tail ? ST_HOLD : ST_WAIT_TAIL;
        else if (load_tail) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (ready_in) state_d = load_head ? (f_tail ? ST_HOLD : ST_WAIT_TAIL) : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    valid_out      = (state_q == ST_HOLD);
    flit_ready_out = (state_q != ST_HOLD) | ready_in;
  end

  // Datapath next state
  always_comb begin
    data_d = data_q;
    dst_d  = dst_q;
    vc_d   = vc_q;
    if (load_head) begin
      data_d = head_word;
      dst_d  = f_dst;
      vc_d   = f_vc;
    end else if (load_tail) begin
      data_d = tail_word;
    end
    err_d = (err_ev && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dst_q  <= '0;
      vc_q   <= '0;
      err_q  <= '0;
    end else begin
      data_q <= data_d;
      dst_q  <= dst_d;
      vc_q   <= vc_d;
      err_q  <= err_d;
    end
  end

  assign data_out  = data_q;
  assign dst_out   = dst_q;
  assign vc_out    = vc_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_depacketizer_2.sv
// Directed bench for depacketizer_2 with default parameters.
module tb_depacketizer_2;

  logic        clk;
  logic        rst_n;
  logic [17:0] flit_in;
  logic        flit_valid_in;
  logic        flit_ready_out;
  logic [11:0] data_out;
  logic [3:0]  dst_out;
  logic [0:0]  vc_out;
  logic        valid_out;
  logic        ready_in;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  depacketizer_2 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flit_in       (flit_in),
    .flit_valid_in (flit_valid_in),
    .flit_ready_out(flit_ready_out),
    .data_out      (data_out),
    .dst_out       (dst_out),
    .vc_out        (vc_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vi;
    logic [17:0] flit;
    logic        rdy;
    logic        e_valid;
    logic        e_ready;
    logic [11:0] e_data;
    logic [3:0]  e_dst;
    logic        e_vc;
    logic [7:0]  e_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_valid, input logic e_ready,
                           input logic [11:0] e_data, input logic [3:0] e_dst,
                           input logic e_vc, input logic [7:0] e_err);
    check({tag, ".valid_out"},      32'(valid_out),      32'(e_valid));
    check({tag, ".flit_ready_out"}, 32'(flit_ready_out), 32'(e_ready));
    check({tag, ".data_out"},       32'(data_out),       32'(e_data));
    check({tag, ".dst_out"},        32'(dst_out),        32'(e_dst));
    check({tag, ".vc_out"},         32'(vc_out),         32'(e_vc));
    check({tag, ".err_count"},      32'(err_count),      32'(e_err));
  endtask

  task automatic drive(input logic vi, input logic [17:0] f, input logic rdy);
    @(negedge clk);
    flit_valid_in = vi;
    flit_in       = f;
    ready_in      = rdy;
  endtask

  initial begin
    // Head: dst=5 vc=0 payload 10'h2AF; tail: payload top bits 00 -> 12'hABC.
    // Head B: dst=A vc=1 payload 10'h155; tail B: top bits 11 -> 12'h557.
    // Single-flit: dst=3 payload 10'h3FF -> 12'hFFC.
    //          vi  flit       rdy  val rdyo data    dst   vc  err
    vecs[0]  = '{1, 18'h316AF, 1,   0,  1,  12'hABC, 4'h5, 0,  8'd0}; // head -> WAIT
    vecs[1]  = '{1, 18'h28000, 1,   1,  1,  12'hABC, 4'h5, 0,  8'd0}; // tail -> HOLD
    vecs[2]  = '{0, 18'h00000, 1,   0,  1,  12'hABC, 4'h5, 0,  8'd0}; // consumed
    vecs[3]  = '{1, 18'h28000, 1,   0,  1,  12'hABC, 4'h5, 0,  8'd1}; // tail in IDLE
    vecs[4]  = '{1, 18'h00000, 1,   0,  1,  12'hABC, 4'h5, 0,  8'd1}; // valid bit 0
    vecs[5]  = '{1, 18'h316AF, 1,   0,  1,  12'hABC, 4'h5, 0,  8'd1}; // head A
    vecs[6]  = '{1, 18'h36955, 1,   0,  1,  12'h554, 4'hA, 1,  8'd2}; // head B replaces
    vecs[7]  = '{1, 18'h2F000, 0,   1,  0,  12'h557, 4'hA, 1,  8'd2}; // tail B, stalled
    vecs[8]  = '{0, 18'h00000, 0,   1,  0,  12'h557, 4'hA, 1,  8'd2}; // stall
    vecs[9]  = '{0, 18'h00000, 0,   1,  0,  12'h557, 4'hA, 1,  8'd2}; // stall
    vecs[10] = '{1, 18'h316AF, 1,   0,  1,  12'hABC, 4'h5, 0,  8'd2}; // release + head
    vecs[11] = '{1, 18'h20000, 1,   0,  1,  12'hABC, 4'h5, 0,  8'd3}; // body tail=0
    vecs[12] = '{1, 18'h28000, 1,   1,  1,  12'hABC, 4'h5, 0,  8'd3}; // tail -> HOLD
    vecs[13] = '{0, 18'h316AF, 1,   0,  1,  12'hABC, 4'h5, 0,  8'd3}; // vi=0 ignored
    vecs[14] = '{1, 18'h38FFF, 1,   1,  1,  12'hFFC, 4'h3, 0,  8'd3}; // single flit
    vecs[15] = '{0, 18'h00000, 1,   0,  1,  12'hFFC, 4'h3, 0,  8'd3}; // consumed

    rst_n         = 1'b0;
    flit_in       = '0;
    flit_valid_in = 1'b0;
    ready_in      = 1'b0;
    #12;
    check_all("reset", 1'b0, 1'b1, 12'h000, 4'h0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].vi, vecs[i].flit, vecs[i].rdy);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                vecs[i].e_data, vecs[i].e_dst, vecs[i].e_vc, vecs[i].e_err);
    end

    // Error counter saturation: 260 stray tails in IDLE, starting from 3.
    drive(1'b1, 18'h28000, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    check("sat.err_mid", 32'(err_count), 32'd103);
    check("sat.valid_mid", 32'(valid_out), 32'd0);
    repeat (160) @(posedge clk);
    #1;
    check("sat.err_end", 32'(err_count), 32'd255);

    // Reset in the middle of WAIT_TAIL.
    drive(1'b1, 18'h316AF, 1'b1);
    @(posedge clk);
    #1;
    check_all("pre_rst", 1'b0, 1'b1, 12'hABC, 4'h5, 1'b0, 8'd255);
    #2;
    rst_n         = 1'b0;
    flit_valid_in = 1'b0;
    #1;
    check_all("mid_rst", 1'b0, 1'b1, 12'h000, 4'h0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Partial packet gone: its tail is now a stray tail in IDLE.
    drive(1'b1, 18'h28000, 1'b1);
    @(posedge clk);
    #1;
    check_all("post_rst", 1'b0, 1'b1, 12'h000, 4'h0, 1'b0, 8'd1);
    drive(1'b0, 18'h00000, 1'b1);
    @(posedge clk);
    #1;
    check("post_rst.idle_valid", 32'(valid_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
